oam_dma_ctrl: RTL
=================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL: clk_ph1  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL: cpu_addr  input  16  CPU address bus (Addr_bus).
REQ-004 SHALL: cpu_dout  input  8  CPU write data (Data_bus_out).
REQ-005 SHALL: cpu_r_nw  input  1  CPU read/not-write (R_nW).
REQ-006 SHALL: mem_din  input  8  read data returned by the memory map for bus_addr.
REQ-007 SHALL: bus_addr  output  16  address presented to the memory map.
REQ-008 SHALL: bus_dout  output  8  write data presented to the memory map.
REQ-009 SHALL: bus_r_nw  output  1  read/not-write presented to the memory map.
REQ-010 SHALL: cpu_rdy  output  1  1 = CPU runs, 0 = CPU halted.
REQ-011 SHALL: dma_active  output  1  1 in any non-IDLE state.
REQ-012 SHALL: dma_done  output  1  one-cycle pulse on return to IDLE after the final write.

Function
REQ-013 SHALL: States are IDLE, HALT, ALIGN, READ and WRITE; the 8-bit offset register is idx; the page register is page; the read latch is dlat.
REQ-014 SHALL: IDLE outputs: bus_addr = cpu_addr, bus_dout = cpu_dout, bus_r_nw = cpu_r_nw, cpu_rdy = 1 (combinational passthrough).
REQ-015 SHALL: Trigger condition: in IDLE, cpu_r_nw = 0 and cpu_addr = 16'h4014 at a clock edge.
REQ-016 SHALL: On a trigger, the block latches page <= cpu_dout, sets idx <= 0 and moves to HALT; that CPU write still passes through to the bus.
REQ-017 SHALL: A read of 16'h4014, or a write to any other address, causes no trigger.
REQ-018 SHALL: cpu_rdy = 0 in HALT, ALIGN, READ and WRITE.
REQ-019 SHALL: In HALT and ALIGN the block drives a dummy read: bus_addr = {page,8'h00}, bus_r_nw = 1, with mem_din ignored.
REQ-020 SHALL: A free-running parity bit toggles every clock, including during DMA.
REQ-021 SHALL: HALT lasts one cycle, then goes to ALIGN if parity = 1 during HALT (and REQ-033 applies), otherwise to READ.
REQ-022 SHALL: ALIGN lasts one cycle, then goes to READ.
REQ-023 SHALL: READ drives bus_addr = {page,idx} and bus_r_nw = 1, latches dlat <= mem_din at the edge, then goes to WRITE.
REQ-024 SHALL: WRITE drives bus_addr = 16'h2004, bus_dout = dlat and bus_r_nw = 0, then idx <= idx+1 (mod 256).
REQ-025 SHALL: From WRITE, if idx = 8'hFF the block goes to IDLE and pulses dma_done for the following cycle; otherwise it goes to READ.
REQ-026 SHALL: Total halt length is 513 cycles without ALIGN and 514 with ALIGN.
REQ-027 SHALL: Page 8'hFF reads 16'hFF00-16'hFFFF; idx wraps to 0 and no carry reaches page.
REQ-028 SHALL: Any trigger pattern seen while not IDLE is ignored.

Reset
REQ-029 SHALL: With rst = 1 at an edge: state <= IDLE, idx <= 0, page <= 0, dlat <= 0, parity <= 0, dma_done <= 0.
REQ-030 SHALL: Immediately after reset, outputs are cpu_rdy = 1, dma_active = 0 and bus passthrough per REQ-014.
REQ-031 SHALL: Reset during DMA aborts the transfer at the next edge; no further DMA bus cycles occur and dma_done is not pulsed.
REQ-032 SHALL: rst takes priority over a simultaneous trigger.

Configuration
REQ-033 SHALL: Macro OAM_DMA_ALIGN_EN: when defined, the ALIGN state and the parity decision are compiled in (REQ-021); when undefined, HALT always goes to READ, the parity logic is absent, and the halt length is always 513 cycles.

Verification
REQ-034 SHALL: Reset: rst = 1 for 2 cycles with cpu_addr = 16'h1234 -> cpu_rdy = 1, dma_active = 0, bus_addr = 16'h1234.
REQ-035 SHALL: Trigger with 8'h02 written to 16'h4014 at parity 0 -> reads of 16'h0200-16'h02FF, each followed by a write of the same byte to 16'h2004; cpu_rdy low for exactly 513 cycles; one dma_done pulse.
REQ-036 SHALL: Same trigger at parity 1 -> 514 cycles with OAM_DMA_ALIGN_EN defined, 513 cycles without.
REQ-037 SHALL: Trigger with page 8'hFF -> last read at 16'hFFFF, then IDLE; no access to 16'h0000.
REQ-038 SHALL: rst = 1 on cycle 100 of a transfer -> IDLE and cpu_rdy = 1 the next cycle; a new trigger with 8'h03 starts at 16'h0300.
REQ-039 SHALL: A read of 16'h4014 and a write of 8'h02 to 16'h4015 -> no trigger; cpu_rdy stays 1.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// ============================================================================
// Module  : oam_dma_ctrl
// Brief   : Sprite OAM DMA engine. Halts the CPU and copies one 256-byte page
//           to the OAM data port at 16'h2004. Define OAM_DMA_ALIGN_EN to add
//           the parity-driven ALIGN cycle.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module oam_dma_ctrl (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_r_nw,
    input  logic [7:0]  mem_din,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_r_nw,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic        dma_done
);

    localparam logic [15:0] C_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] C_OAM_ADDR  = 16'h2004;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q,   idx_d;
    logic [7:0]  page_q,  page_d;
    logic [7:0]  dlat_q,  dlat_d;
    logic        done_q,  done_d;
    logic        trig_w;

`ifdef OAM_DMA_ALIGN_EN
    logic        parity_q;

    always_ff @(posedge clk_ph1) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= ~parity_q;
    end
`endif

    assign trig_w = (cpu_addr == C_TRIG_ADDR) && !cpu_r_nw;

    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 8'h00;
            page_q  <= 8'h00;
            dlat_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            dlat_q  <= dlat_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        page_d   = page_q;
        dlat_d   = dlat_q;
        done_d   = 1'b0;
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_r_nw = cpu_r_nw;
        cpu_rdy  = 1'b1;
        case (state_q)
            S_IDLE: begin
                // The triggering CPU write itself still reaches the bus.
                if (trig_w) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                cpu_rdy  = 1'b0;
                bus_addr = {page_q, 8'h00};
                bus_dout = 8'h00;
                bus_r_nw = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
                state_d  = parity_q ? S_ALIGN : S_READ;
`else
                state_d  = S_READ;
`endif
            end
            S_ALIGN: begin
                cpu_rdy  = 1'b0;
                bus_addr = {page_q, 8'h00};
                bus_dout = 8'h00;
                bus_r_nw = 1'b1;
                state_d  = S_READ;
            end
            S_READ: begin
                cpu_rdy  = 1'b0;
                bus_addr = {page_q, idx_q};
                bus_dout = 8'h00;
                bus_r_nw = 1'b1;
                dlat_d   = mem_din;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                cpu_rdy  = 1'b0;
                bus_addr = C_OAM_ADDR;
                bus_dout = dlat_q;
                bus_r_nw = 1'b0;
                // idx wraps inside the page; page is never incremented.
                idx_d    = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dma_active = (state_q != S_IDLE);
    assign dma_done   = done_q;

endmodule

`default_nettype wire
